// File: rtl/periph_bridge.sv
// Bridge from the picorv32 native memory interface to the slot-decoded peripheral request bus.
// Every output is registered; output register inputs are computed from the next state.
module periph_bridge #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NSLV       = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int                    SLOT_BITS  = 12,
  parameter int                    RD_LAT     = 1
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       mem_valid,
  input  logic                       mem_instr,
  input  logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic [NSLV-1:0]            w_REQ,
  output logic [NSLV-1:0]            r_REQ,
  output logic [ADDR_WIDTH-1:0]      w_ADDR,
  output logic [ADDR_WIDTH-1:0]      r_ADDR,
  output logic [DATA_WIDTH-1:0]      w_DATA,
  input  logic [NSLV*DATA_WIDTH-1:0] r_DATA_BUS,
  input  logic                       iERR_CLR,
  output logic                       oERR,
  output logic [ADDR_WIDTH-1:0]      oERR_ADDR
);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP, ERR} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, slot_q, slot_dec;
  logic [ADDR_WIDTH-1:0]   off, slot_full;
  logic                    hit, bad;

  logic                    ready_d, err_d;
  logic [NSLV-1:0]         w_req_d, r_req_d;
  logic [DATA_WIDTH-1:0]   rdata_d, wdata_d;
  logic [ADDR_WIDTH-1:0]   waddr_d, raddr_d, err_addr_d;

  always_comb begin
    off       = mem_addr - BASE_ADDR;
    slot_full = off >> SLOT_BITS;
    slot_dec  = slot_full[3:0];
    hit       = (mem_addr >= BASE_ADDR) && (slot_full < ADDR_WIDTH'(NSLV));
    bad       = !hit || mem_instr || !(mem_wstrb == 4'h0 || mem_wstrb == 4'hF);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_valid) slot_q <= slot_dec;
      if (state_q == RD)            cnt_q <= 4'(RD_LAT);
      else if (state_q == RWAIT)    cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (bad)                     state_d = ERR;
          else if (mem_wstrb == 4'hF)  state_d = WR;
          else                         state_d = RD;
        end
      end
      WR:      state_d = IDLE;
      RD:      state_d = RWAIT;
      RWAIT:   if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    ready_d    = (state_d == WR) || (state_d == RESP) || (state_d == ERR);
    w_req_d    = '0;
    r_req_d    = '0;
    waddr_d    = w_ADDR;
    wdata_d    = w_DATA;
    raddr_d    = r_ADDR;
    rdata_d    = mem_rdata;
    err_d      = oERR;
    err_addr_d = oERR_ADDR;
    if (iERR_CLR) err_d = 1'b0;
    // WR, RD and ERR are only ever entered from IDLE, so the live bus inputs are the transaction.
    case (state_d)
      WR: begin
        w_req_d = NSLV'(1) << slot_dec;
        waddr_d = mem_addr;
        wdata_d = mem_wdata;
      end
      RD: begin
        r_req_d = NSLV'(1) << slot_dec;
        raddr_d = mem_addr;
      end
      ERR: begin
        rdata_d = '0;
        err_d   = 1'b1;
        if (!oERR || iERR_CLR) err_addr_d = mem_addr;
      end
      default: ;
    endcase
    if (state_q == RWAIT && cnt_q == 4'd1)
      rdata_d = r_DATA_BUS[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      w_REQ     <= '0;
      r_REQ     <= '0;
      w_ADDR    <= '0;
      r_ADDR    <= '0;
      w_DATA    <= '0;
      oERR      <= 1'b0;
      oERR_ADDR <= '0;
    end else begin
      mem_ready <= ready_d;
      mem_rdata <= rdata_d;
      w_REQ     <= w_req_d;
      r_REQ     <= r_req_d;
      w_ADDR    <= waddr_d;
      r_ADDR    <= raddr_d;
      w_DATA    <= wdata_d;
      oERR      <= err_d;
      oERR_ADDR <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_periph_bridge.sv
// Randomized bench for periph_bridge; each transaction is predicted cycle by cycle from the
// decode rules and latencies and compared against every registered output.
module tb_periph_bridge;

  localparam int          AW        = 32;
  localparam int          DW        = 32;
  localparam int          NSLV      = 4;
  localparam int          SLOT_BITS = 12;
  localparam int          RD_LAT    = 1;
  localparam logic [31:0] BASE      = 32'h1000_0000;

  logic                 iCLK = 1'b0;
  logic                 iRST;
  logic                 mem_valid, mem_instr;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [3:0]           mem_wstrb;
  logic                 mem_ready;
  logic [DW-1:0]        mem_rdata;
  logic [NSLV-1:0]      w_REQ, r_REQ;
  logic [AW-1:0]        w_ADDR, r_ADDR, oERR_ADDR;
  logic [DW-1:0]        w_DATA;
  logic [NSLV*DW-1:0]   r_DATA_BUS;
  logic                 iERR_CLR, oERR;

  periph_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NSLV(NSLV), .BASE_ADDR(BASE),
    .SLOT_BITS(SLOT_BITS), .RD_LAT(RD_LAT)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .w_REQ(w_REQ), .r_REQ(r_REQ), .w_ADDR(w_ADDR), .r_ADDR(r_ADDR), .w_DATA(w_DATA),
    .r_DATA_BUS(r_DATA_BUS), .iERR_CLR(iERR_CLR), .oERR(oERR), .oERR_ADDR(oERR_ADDR)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  // Reference state: what the registered outputs should currently hold.
  logic [DW-1:0] exp_rdata, exp_wdata;
  logic [AW-1:0] exp_waddr, exp_raddr, exp_err_addr;
  logic          exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic model_reset();
    exp_rdata = '0; exp_wdata = '0; exp_waddr = '0; exp_raddr = '0;
    exp_err_addr = '0; exp_err = 1'b0;
  endtask

  function automatic void decode(input logic [31:0] addr, output bit hit, output int slot);
    longint unsigned off;
    hit  = 1'b0;
    slot = 0;
    if (addr >= BASE) begin
      off  = longint'(addr) - longint'(BASE);
      hit  = (off / (64'd1 << SLOT_BITS)) < NSLV;
      if (hit) slot = int'(off / (64'd1 << SLOT_BITS));
    end
  endfunction

  task automatic drive_bus(input int slot, input logic [31:0] val, input bit real_data);
    for (int i = 0; i < NSLV; i++)
      r_DATA_BUS[i*DW +: DW] = (real_data && i == slot) ? val : $urandom;
  endtask

  task automatic check_all(input string tag, input logic [3:0] ew, input logic [3:0] er, input bit erdy);
    check({tag, " w_REQ"},     32'(w_REQ), 32'(ew));
    check({tag, " r_REQ"},     32'(r_REQ), 32'(er));
    check({tag, " mem_ready"}, 32'(mem_ready), 32'(erdy));
    check({tag, " mem_rdata"}, mem_rdata, exp_rdata);
    check({tag, " w_ADDR"},    w_ADDR, exp_waddr);
    check({tag, " w_DATA"},    w_DATA, exp_wdata);
    check({tag, " r_ADDR"},    r_ADDR, exp_raddr);
    check({tag, " oERR"},      32'(oERR), 32'(exp_err));
    check({tag, " oERR_ADDR"}, oERR_ADDR, exp_err_addr);
  endtask

  // Presents one transaction in the current cycle (cycle 0) and checks cycles 1..lat+1.
  // Returns in cycle lat+1, the first cycle a new transaction may be presented.
  task automatic txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input bit instr, input bit clr, input logic [31:0] rval);
    bit hit; int slot; bit err, is_wr; int lat; logic [3:0] oh;
    decode(addr, hit, slot);
    err   = !hit || instr || !(wstrb == 4'h0 || wstrb == 4'hF);
    is_wr = !err && wstrb == 4'hF;
    lat   = (err || is_wr) ? 1 : 2 + RD_LAT;
    oh    = '0;
    if (!err) oh[slot] = 1'b1;
    mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wdata = wdata;
    mem_wstrb = wstrb; iERR_CLR = clr;
    drive_bus(slot, rval, 1'b0);
    for (int k = 1; k <= lat + 1; k++) begin
      step();
      iERR_CLR = 1'b0;
      // The bridge is busy until after mem_ready, so this noise must be ignored.
      mem_valid = (k <= lat) ? 1'($urandom) : 1'b0;
      mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom); mem_instr = 1'($urandom);
      drive_bus(slot, rval, !err && !is_wr && k == 1 + RD_LAT);
      if (k == 1) begin
        if (err) begin
          if (!exp_err || clr) exp_err_addr = addr;
          exp_err = 1'b1;
        end else begin
          if (clr) exp_err = 1'b0;
          if (is_wr) begin exp_waddr = addr; exp_wdata = wdata; end
          else       exp_raddr = addr;
        end
      end
      if (k == lat && !is_wr) exp_rdata = err ? '0 : rval;
      check_all($sformatf("%s c%0d", name, k),
                (is_wr && k == 1) ? oh : 4'h0,
                (!err && !is_wr && k == 1) ? oh : 4'h0,
                k == lat);
    end
  endtask

  task automatic random_txn(input int n);
    logic [31:0] addr; logic [3:0] wstrb;
    case ($urandom_range(0, 5))
      0, 1, 2: addr = BASE + 32'($urandom_range(0, NSLV-1)) * 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
      3:       addr = BASE + 32'($urandom_range(NSLV, 40)) * 32'h1000 + 32'($urandom_range(0, 4095));
      4:       addr = BASE - 32'($urandom_range(1, 8192));
      default: addr = $urandom;
    endcase
    if ($urandom_range(0, 3) == 0) wstrb = 4'($urandom);
    else                           wstrb = $urandom_range(0, 1) ? 4'hF : 4'h0;
    txn($sformatf("rnd%0d", n), addr, $urandom, wstrb,
        $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom);
  endtask

  initial begin
    iRST = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_wstrb = '0; iERR_CLR = 1'b0; r_DATA_BUS = '0;
    model_reset();
    repeat (3) step();
    check_all("reset", 4'h0, 4'h0, 1'b0);
    iRST = 1'b0;
    step();

    txn("wr_slot0",  32'h1000_0000, 32'h0000_00A5, 4'hF, 1'b0, 1'b0, 32'h0);
    txn("rd_slot1",  32'h1000_1004, 32'h0,         4'h0, 1'b0, 1'b0, 32'h1234_5678);
    txn("rd_unmap",  32'h1000_4000, 32'h0,         4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    txn("wr_part",   32'h1000_0000, 32'h5555_5555, 4'h3, 1'b0, 1'b0, 32'h0);
    txn("ifetch_clr",32'h1000_0000, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0);

    iERR_CLR = 1'b1;
    step();
    iERR_CLR = 1'b0;
    exp_err = 1'b0;
    check_all("clr_only", 4'h0, 4'h0, 1'b0);

    // Reset during RWAIT abandons the read.
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h1000_2008; mem_wstrb = 4'h0;
    drive_bus(2, 32'hCAFE_F00D, 1'b1);
    step();
    mem_valid = 1'b0;
    check("rst_rd r_REQ", 32'(r_REQ), 32'h4);
    step();
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    model_reset();
    check_all("rst_rwait", 4'h0, 4'h0, 1'b0);
    step();
    check_all("rst_after", 4'h0, 4'h0, 1'b0);

    txn("wr_after_rst", 32'h1000_3010, 32'h0BAD_C0DE, 4'hF, 1'b0, 1'b0, 32'h0);
    txn("b2b_slot2",    32'h1000_2000, 32'h2222_2222, 4'hF, 1'b0, 1'b0, 32'h0);
    txn("b2b_slot3",    32'h1000_3000, 32'h3333_3333, 4'hF, 1'b0, 1'b0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      random_txn(n);
      if ($urandom_range(0, 3) == 0) begin
        step();
        check_all($sformatf("gap%0d", n), 4'h0, 4'h0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
